adder_datapath_control_n: RTL and testbench
===========================================

// Module: adder_datapath_control_n
//
// PURPOSE
// - Parametrised successor to the 16-bit adder datapath/control block.
// - Accepts a stream of COUNT unsigned operands over a valid/acknowledge handshake,
//   sums them, and presents one widened result over a second handshake.
// - The output side supports backpressure.
// - Sits between a producer (e.g. switch/register front end) and a consumer (display/next stage).
//
// PARAMETERS
// - WIDTH  16  operand width in bits, >= 1
// - COUNT  4   operands summed per result, >= 2
// - SUM_W  WIDTH+$clog2(COUNT)  result width (localparam, not overridable)
//
// PORTS
// - clk    in   1      single clock; all state updates on rising edge
// - reset  in   1      asynchronous, active-low reset
// - din    in   WIDTH  operand, unsigned
// - irdy   in   1      producer asserts: din valid this cycle
// - iack   out  1      block can take din this cycle; operand accepted when irdy & iack at clk edge
// - dout   out  SUM_W  sum of last COUNT accepted operands
// - ordy   out  1      dout valid
// - oack   in   1      consumer takes dout; transfer when ordy & oack at clk edge
//
// BEHAVIOUR
// - Reset (reset==0, async): state=ACCUM, cnt=0, acc=0, dout=0, ordy=0; iack reads 1 once reset releases.
// - States:
//   - ACCUM: iack=1, ordy=0.
//   - DONE:  iack=0, ordy=1.
// - iack is combinational from state only, never from irdy.
// - ACCUM, on accept:
//   - acc <= (cnt==0) ? zext(din) : acc + zext(din).
//   - cnt <= cnt+1.
//   - When cnt==COUNT-1: dout <= final sum, cnt <= 0, go to DONE.
// - ACCUM with irdy==0: hold all state; gaps between operands are allowed.
// - Latency: ordy rises the cycle after the edge that accepted the COUNT-th operand.
// - DONE: dout and ordy hold stable until the ordy & oack edge, then return to ACCUM.
// - One-cycle bubble after each result: no operand accepted in the oack cycle.
// - oack while ordy==0 is ignored. irdy while iack==0 is ignored; the operand is not consumed.
// - Arithmetic: unsigned, zero-extended to SUM_W.
//   - Without the macro, no overflow is possible: COUNT*(2^WIDTH-1) <= 2^SUM_W-1.
// - cnt width is $clog2(COUNT). cnt wraps to 0 only via the final-operand rule.
// - Reset mid-sum or during DONE: partial sum and held result are discarded; returns to reset values.
// - Inputs are sampled only at clk edges; no combinational path din->dout.
//
// CONFIGURATION
// - Macro ADDER_DC_SATURATE_EN:
//   - Defined: final sum clamps to 2^WIDTH-1 when it exceeds that value.
//     - dout stays SUM_W wide; upper SUM_W-WIDTH bits are then always 0.
//     - Clamping applies to the result only, not to intermediate acc.
//   - Undefined: full-precision sum, no clamping.
//
// TESTING (WIDTH=16, COUNT=4; clk period 20 ns; reset low for 100 ns)
// 1. Basic sum:
//    - Stimulus: operands 0x0001,0x0002,0x0003,0x0004 back-to-back with irdy=1; oack=1.
//    - Required: ordy=1 one cycle after the 4th accept, dout=0x0000A; next cycle ordy=0, iack=1.
// 2. Max values:
//    - Stimulus: 4 x 0xFFFF.
//    - Required: dout=0x3FFFC without the macro; dout=0x0FFFF with ADDER_DC_SATURATE_EN.
// 3. Input gaps:
//    - Stimulus: operands 5,6,7,8 with irdy low 1-3 random cycles between them.
//    - Required: dout=0x0001A. irdy-low cycles must not advance cnt.
// 4. Output backpressure:
//    - Stimulus: oack=0 for 5 cycles after ordy rises, irdy=1 with din=0x00FF throughout.
//    - Required: dout stable, iack=0, no operand consumed.
//    - Then oack=1: ordy falls, and the next sum starts fresh with the next accepted operand.
// 5. Reset mid-operation:
//    - Stimulus: accept 0x0010,0x0020, pulse reset low 1 cycle, then send 1,1,1,1.
//    - Required: dout=0x00004 (partial sum discarded). ordy=0 and dout=0 while reset is low.
// 6. Back-to-back results:
//    - Stimulus: 3 consecutive groups with oack tied high.
//    - Required: three correct sums, each ordy pulse exactly 1 cycle, one bubble cycle between groups.

Source files
------------

// File: rtl/adder_datapath_control_n.sv
// Sums COUNT unsigned operands from a valid/ack stream into one widened result (ADDER_DC_SATURATE_EN clamps it to WIDTH bits).
// Latency: ordy rises the cycle after the edge that accepts the COUNT-th operand.
// Backpressure: the result is held while oack is low, and no operands are taken until it leaves.
module adder_datapath_control_n #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4,
  localparam int SUM_W = WIDTH + $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             irdy,
  output logic             iack,
  output logic [SUM_W-1:0] dout,
  output logic             ordy,
  input  logic             oack
);

  localparam int CNT_W = $clog2(COUNT);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] din_x;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] result;
  logic             accept;
  logic             last;

  assign accept = irdy & iack;
  assign last   = (cnt == CNT_W'(COUNT - 1));
  assign din_x  = {{(SUM_W-WIDTH){1'b0}}, din};
  // First operand of a group overwrites acc, so no separate clear is needed.
  assign sum    = (cnt == '0) ? din_x : acc + din_x;

`ifdef ADDER_DC_SATURATE_EN
  localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  assign result = (sum > SAT_MAX) ? SAT_MAX : sum;
`else
  assign result = sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs depend on state only, never on irdy/oack.
  always_comb begin
    state_nxt = state;
    iack      = 1'b0;
    ordy      = 1'b0;
    case (state)
      ACCUM: begin
        iack = 1'b1;
        if (irdy && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ordy = 1'b1;
        if (oack) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      acc  <= '0;
      dout <= '0;
    end else if (accept) begin
      acc <= sum;
      if (last) begin
        cnt  <= '0;
        dout <= result;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_datapath_control_n.sv
// Scoreboard bench for adder_datapath_control_n at WIDTH=16, COUNT=4.
module tb_adder_datapath_control_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        irdy;
  logic        iack;
  logic [17:0] dout;
  logic        ordy;
  logic        oack;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          grp_n  = 0;
  logic [17:0] grp_sum;
  logic [17:0] sb[$];
  bit          post_xfer = 0;

  adder_datapath_control_n #(.WIDTH(16), .COUNT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .irdy (irdy),
    .iack (iack),
    .dout (dout),
    .ordy (ordy),
    .oack (oack)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [17:0] finalize(input logic [17:0] s);
`ifdef ADDER_DC_SATURATE_EN
    return (s > 18'h0FFFF) ? 18'h0FFFF : s;
`else
    return s;
`endif
  endfunction

  // Holds din/irdy until accepted, then updates the reference model.
  task automatic send_op(input logic [15:0] d);
    int  n    = 0;
    bit  took = 0;
    din  = d;
    irdy = 1'b1;
    while (!took) begin
      @(negedge clk);
      if (iack === 1'b1) took = 1;
      @(posedge clk);
      #1;
      n++;
      if (!took && n > 50) begin
        check("accept_timeout", 32'(n), 32'd0);
        irdy = 1'b0;
        return;
      end
    end
    irdy = 1'b0;
    grp_sum = (grp_n == 0) ? {2'b00, d} : grp_sum + {2'b00, d};
    grp_n++;
    if (grp_n == 4) begin
      sb.push_back(finalize(grp_sum));
      grp_n = 0;
      @(negedge clk);
      check("latency_ordy", 32'(ordy), 32'd1);
    end
  endtask

  // Output side: compare on each transfer, then confirm the bubble cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (post_xfer) begin
        check("bubble_ordy", 32'(ordy), 32'd0);
        check("bubble_iack", 32'(iack), 32'd1);
        post_xfer = 0;
      end
      if (ordy === 1'b1 && oack === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_empty", 32'(dout), 32'hFFFF_FFFF);
        end else begin
          check("dout", 32'(dout), 32'(sb.pop_front()));
        end
        post_xfer = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    din   = '0;
    irdy  = 1'b0;
    oack  = 1'b1;
    #50;
    check("rst_ordy", 32'(ordy), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    #50;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_iack", 32'(iack), 32'd1);

    // basic sum
    send_op(16'h0001); send_op(16'h0002); send_op(16'h0003); send_op(16'h0004);

    // max values
    for (int i = 0; i < 4; i++) send_op(16'hFFFF);

    // gaps between operands
    for (int i = 5; i <= 8; i++) begin
      send_op(16'(i));
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    // output backpressure
    oack = 1'b0;
    send_op(16'h0001); send_op(16'h0002); send_op(16'h0003); send_op(16'h0004);
    din  = 16'h00FF;
    irdy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_ordy", 32'(ordy), 32'd1);
      check("bp_iack", 32'(iack), 32'd0);
      check("bp_dout", 32'(dout), 32'h0000A);
    end
    @(posedge clk);
    #1;
    oack = 1'b1;
    send_op(16'h00FF); send_op(16'h0001); send_op(16'h0001); send_op(16'h0001);

    // reset mid-operation
    send_op(16'h0010);
    send_op(16'h0020);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ordy", 32'(ordy), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    grp_n = 0;
    for (int i = 0; i < 4; i++) send_op(16'h0001);

    // back-to-back groups
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) send_op(16'($urandom_range(0, 16'hFFFF)));
    end

    for (int n = 0; n < 20 && (sb.size() != 0 || post_xfer); n++) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
